// File: rtl/tetris_sequencer.sv
// Game sequencer for the Tetris datapath: owns the spawn / fall / lock /
// line-clear / game-over state machine and produces the next shape code,
// the fall speed and the score. All outputs come from registers.
module tetris_sequencer #(
  parameter int TICK_DIV   = 3500000,
  parameter int SPEED_INIT = 5,
  parameter int SPEED_STEP = 2,
  parameter int SPEED_MAX  = 25
) (
  input  logic        iVGA_CLK,
  input  logic        reset,
  input  logic        start,
  input  logic        landed,
  input  logic [9:0]  piece_y,
  input  logic        rows_full,
  input  logic        clear_done,
  output logic        tick,
  output logic        spawn,
  output logic [2:0]  shape,
  output logic        lock,
  output logic        clear_req,
  output logic [4:0]  speed,
  output logic [15:0] score,
  output logic        game_over
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SPAWN = 3'd1;
  localparam logic [2:0] S_FALL  = 3'd2;
  localparam logic [2:0] S_LOCK  = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;
  localparam logic [2:0] S_CLEAR = 3'd5;
  localparam logic [2:0] S_OVER  = 3'd6;

  localparam logic [31:0] TICK_LAST    = 32'(TICK_DIV - 1);
  localparam logic [4:0]  SPEED_INIT_V = 5'(SPEED_INIT);
  localparam logic [5:0]  SPEED_STEP_V = 6'(SPEED_STEP);
  localparam logic [5:0]  SPEED_MAX_V  = 6'(SPEED_MAX);

  logic [2:0]  state_reg, state_next;
  logic [31:0] cnt_reg;
  logic [7:0]  lfsr_reg;
  logic [2:0]  shape_reg;
  logic [4:0]  speed_reg;
  logic [15:0] score_reg;
  logic        tick_reg;

  logic [2:0]  shape_next;
  logic [5:0]  speed_sum;
  logic [4:0]  speed_next;
  logic        new_game;
  logic        row_cleared;

  // Next-state decode; inputs are only looked at in the states that own them
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_SPAWN;
      S_SPAWN: state_next = S_FALL;
      S_FALL:  if (landed) state_next = (piece_y == 10'd0) ? S_OVER : S_LOCK;
      S_LOCK:  state_next = S_CHECK;
      S_CHECK: state_next = rows_full ? S_CLEAR : S_SPAWN;
      S_CLEAR: if (clear_done) state_next = S_CHECK;
      S_OVER:  if (start) state_next = S_SPAWN;
      default: state_next = S_IDLE;
    endcase
  end

  // Shape mapping (code 3 folds onto the square) and saturating speed/score helpers
  always_comb begin
    shape_next  = (lfsr_reg[1:0] == 2'b11) ? 3'd0 : {1'b0, lfsr_reg[1:0]};
    speed_sum   = {1'b0, speed_reg} + SPEED_STEP_V;
    speed_next  = (speed_sum > SPEED_MAX_V) ? SPEED_MAX_V[4:0] : speed_sum[4:0];
    new_game    = ((state_reg == S_IDLE) || (state_reg == S_OVER)) && start;
    row_cleared = (state_reg == S_CLEAR) && clear_done;
  end

  // State, free-running shape LFSR and fall-tick counter
  always_ff @(posedge iVGA_CLK) begin
    if (reset) begin
      state_reg <= S_IDLE;
      lfsr_reg  <= 8'h01;
      cnt_reg   <= 32'd0;
      tick_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      // x^8 + x^6 + x^5 + x^4 + 1, maximal length so the all-zero state is never reached
      lfsr_reg  <= {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
      // Counter only runs in FALL, so it is zero on every FALL entry
      cnt_reg   <= ((state_reg == S_FALL) && (cnt_reg != TICK_LAST)) ? cnt_reg + 32'd1 : 32'd0;
      // A landing in the terminal count cycle suppresses that tick
      tick_reg  <= (state_reg == S_FALL) && !landed && (cnt_reg == TICK_LAST);
    end
  end

  // Shape is captured on the way into SPAWN so it is valid alongside the spawn strobe
  always_ff @(posedge iVGA_CLK) begin
    if (reset) begin
      shape_reg <= 3'd0;
    end else if (state_next == S_SPAWN) begin
      shape_reg <= shape_next;
    end
  end

  // Score and speed: cleared on a new game, bumped once per completed row handshake
  always_ff @(posedge iVGA_CLK) begin
    if (reset) begin
      score_reg <= 16'd0;
      speed_reg <= SPEED_INIT_V;
    end else if (new_game) begin
      score_reg <= 16'd0;
      speed_reg <= SPEED_INIT_V;
    end else if (row_cleared) begin
      score_reg <= (score_reg == 16'hFFFF) ? score_reg : score_reg + 16'd1;
      speed_reg <= speed_next;
    end
  end

  assign tick      = tick_reg;
  assign spawn     = (state_reg == S_SPAWN);
  assign lock      = (state_reg == S_LOCK);
  assign clear_req = (state_reg == S_CLEAR);
  assign game_over = (state_reg == S_OVER);
  assign shape     = shape_reg;
  assign speed     = speed_reg;
  assign score     = score_reg;

endmodule

// File: tb/tb_tetris_sequencer.sv
// Self-checking bench for tetris_sequencer: directed game flow with randomized
// fall lengths, landing heights, row counts and clear latencies.
module tb_tetris_sequencer;

  localparam int TICK_DIV = 10;

  logic        iVGA_CLK = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        landed = 1'b0;
  logic [9:0]  piece_y = 10'd0;
  logic        rows_full = 1'b0;
  logic        clear_done = 1'b0;
  logic        tick, spawn, lock, clear_req, game_over;
  logic [2:0]  shape;
  logic [4:0]  speed;
  logic [15:0] score;

  int checks = 0;
  int errors = 0;

  // Reference: LFSR value in the current cycle and in the previous one
  logic [7:0] m_lfsr = 8'h01;
  logic [7:0] m_lfsr_prev = 8'h01;
  int m_score = 0;
  int m_speed = 5;

  tetris_sequencer #(
    .TICK_DIV(TICK_DIV), .SPEED_INIT(5), .SPEED_STEP(2), .SPEED_MAX(25)
  ) dut (
    .iVGA_CLK(iVGA_CLK), .reset(reset), .start(start), .landed(landed),
    .piece_y(piece_y), .rows_full(rows_full), .clear_done(clear_done),
    .tick(tick), .spawn(spawn), .shape(shape), .lock(lock),
    .clear_req(clear_req), .speed(speed), .score(score), .game_over(game_over)
  );

  always #5 iVGA_CLK = ~iVGA_CLK;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic int shape_of(input logic [7:0] v);
    int r;
    r = int'(v) % 4;
    return (r == 3) ? 0 : r;
  endfunction

  // Generator advances on every clock not under reset
  always @(posedge iVGA_CLK) begin
    m_lfsr_prev = m_lfsr;
    m_lfsr = reset ? 8'h01 : lfsr_step(m_lfsr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge iVGA_CLK);
    @(negedge iVGA_CLK);
    chk("strobe_exclusive", 32'((int'(tick) + int'(spawn) + int'(lock)) <= 1), 32'd1);
  endtask

  task automatic row_cleared_model();
    m_score = (m_score == 65535) ? 65535 : m_score + 1;
    m_speed = (m_speed + 2 > 25) ? 25 : m_speed + 2;
  endtask

  task automatic expect_spawn(input string tag);
    chk({tag, "_spawn"}, spawn, 1);
    chk({tag, "_shape"}, shape, shape_of(m_lfsr_prev));
    chk({tag, "_score"}, score, m_score);
    chk({tag, "_speed"}, speed, m_speed);
    chk({tag, "_game_over"}, game_over, 0);
    chk({tag, "_clear_req"}, clear_req, 0);
  endtask

  // Starts at the negedge of a FALL cycle whose index since FALL entry is k0.
  // Returns at the FALL entry of the next piece, or in OVER on a top-out.
  task automatic run_piece(input int k0, input int nfall, input logic [9:0] y,
                           input int nrows, input int mind, input int maxd);
    int d;
    for (int i = 1; i <= nfall; i++) begin
      start = 1'($urandom);       // ignored while falling
      clear_done = 1'($urandom);  // ignored while falling
      rows_full = 1'($urandom);
      step();
      chk("tick_cadence", tick, 32'(((k0 + i) % TICK_DIV) == 0));
      chk("score_hold_fall", score, m_score);
    end
    start = 1'b0; clear_done = 1'b0; rows_full = 1'b0;
    landed = 1'b1; piece_y = y;
    step();
    landed = 1'b0;
    chk("no_tick_after_land", tick, 0);
    if (y == 10'd0) begin
      chk("topout_game_over", game_over, 1);
      chk("topout_no_lock", lock, 0);
      $display("piece y=%0d top-out score=%0d speed=%0d", y, score, speed);
      return;
    end
    chk("lock_pulse", lock, 1);
    chk("lock_no_game_over", game_over, 0);
    step();
    chk("lock_one_cycle", lock, 0);
    chk("check_no_spawn", spawn, 0);
    chk("check_no_clear_req", clear_req, 0);
    for (int r = 0; r < nrows; r++) begin
      rows_full = 1'b1;
      step();
      rows_full = 1'b0;
      chk("clear_req_rise", clear_req, 1);
      d = $urandom_range(maxd, mind);
      for (int j = 0; j < d; j++) begin
        step();
        chk("clear_req_hold", clear_req, 1);
        chk("score_hold_clear", score, m_score);
      end
      clear_done = 1'b1;
      step();
      clear_done = 1'b0;
      row_cleared_model();
      chk("clear_req_drop", clear_req, 0);
      chk("score_after_clear", score, m_score);
      chk("speed_after_clear", speed, m_speed);
    end
    step();
    expect_spawn("respawn");
    step();
    chk("spawn_one_cycle", spawn, 0);
    chk("fall_entry_tick", tick, 0);
    $display("piece y=%0d rows=%0d score=%0d speed=%0d", y, nrows, score, speed);
  endtask

  initial begin
    repeat (3) step();
    chk("rst_tick", tick, 0);
    chk("rst_spawn", spawn, 0);
    chk("rst_lock", lock, 0);
    chk("rst_clear_req", clear_req, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_score", score, 0);
    chk("rst_speed", speed, 5);
    chk("rst_shape", shape, 0);

    reset = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    m_score = 0; m_speed = 5;
    expect_spawn("first");
    step();
    chk("first_spawn_one_cycle", spawn, 0);

    // 35 cycles of FALL: ticks expected at 10, 20, 30
    run_piece(0, 35, 10'd100, 0, 0, 0);
    // Two rows, each acknowledged three cycles into CLEAR
    run_piece(0, 12, 10'd200, 2, 3, 3);
    chk("two_rows_score", score, 2);
    chk("two_rows_speed", speed, 9);

    for (int p = 0; p < 6; p++) begin
      run_piece(0, $urandom_range(25, 0), 10'($urandom_range(1023, 1)),
                $urandom_range(3, 0), 0, 4);
    end

    // Eleven clears in one lock: speed must pin at the ceiling
    run_piece(0, 5, 10'd300, 11, 0, 0);
    chk("speed_saturated", speed, 25);

    // Top-out, then restart from OVER
    run_piece(0, 7, 10'd0, 0, 0, 0);
    step();
    chk("over_hold", game_over, 1);
    chk("over_no_spawn", spawn, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    m_score = 0; m_speed = 5;
    expect_spawn("restart");
    step();

    // One cleared row, then reset in the middle of the next clear handshake
    run_piece(0, 3, 10'd60, 1, 1, 1);
    landed = 1'b1; piece_y = 10'd50;
    step();
    landed = 1'b0;
    chk("mid_lock", lock, 1);
    step();
    rows_full = 1'b1;
    step();
    rows_full = 1'b0;
    chk("mid_clear_req", clear_req, 1);
    step();
    chk("mid_clear_req_hold", clear_req, 1);
    reset = 1'b1;
    step();
    chk("midrst_clear_req", clear_req, 0);
    chk("midrst_score", score, 0);
    chk("midrst_speed", speed, 5);
    chk("midrst_shape", shape, 0);
    chk("midrst_game_over", game_over, 0);
    chk("midrst_spawn", spawn, 0);
    reset = 1'b0;
    step();
    chk("idle_no_spawn", spawn, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    m_score = 0; m_speed = 5;
    expect_spawn("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
